// File: rtl/out_pack_fifo.sv
// out_pack_fifo: requantizes signed accumulator words to IO_DATA_WIDTH,
// packs them into groups of up to three lanes and queues the groups in a
// DEPTH-entry FIFO for an external bus driver.
//
// Ports:
//   clk, arst_n_in           clock (rising edge), async active-low reset
//   clear                    synchronous flush of packer, FIFO and sat_seen
//   shamt                    arithmetic right-shift amount (static while busy)
//   in_valid/in_ready/in_data/in_last   word input handshake; in_last closes a group
//   out_valid/out_ready      head-group handshake
//   out_1..out_3, out_lanes  head-group lanes and valid lane count (1..3)
//   drive_en                 bus drive request, equals out_valid
//   sat_seen                 sticky saturation flag
//
// Optional feature: define OUT_PACK_ROUND_EN for round-half-up before the shift.
module out_pack_fifo #(
    parameter int unsigned IO_DATA_WIDTH      = 16,
    parameter int unsigned ACCUMULATION_WIDTH = 32,
    parameter int unsigned DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          clear,
    input  logic [4:0]                    shamt,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IO_DATA_WIDTH-1:0]      out_1,
    output logic [IO_DATA_WIDTH-1:0]      out_2,
    output logic [IO_DATA_WIDTH-1:0]      out_3,
    output logic [1:0]                    out_lanes,
    output logic                          drive_en,
    output logic                          sat_seen
);

    localparam int unsigned IW = IO_DATA_WIDTH;
    localparam int unsigned AW = ACCUMULATION_WIDTH;
    localparam int unsigned XW = AW + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    // Saturation bounds at the extended width; ~(2^k-1) == -2^k.
    localparam logic signed [XW-1:0] SAT_HI = {{(XW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

    logic [IW-1:0] mem_1 [DEPTH];
    logic [IW-1:0] mem_2 [DEPTH];
    logic [IW-1:0] mem_3 [DEPTH];
    logic [1:0]    mem_n [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [IW-1:0] pk_1, pk_2;
    logic [1:0]    pk_cnt;
    logic          sat_q;

    logic                 accept, pop, close;
    logic signed [XW-1:0] ext, shf;
    logic [IW-1:0]        qword;
    logic                 qsat;
    logic [IW-1:0]        grp_1, grp_2, grp_3;
    logic [1:0]           grp_n;

    // Handshake decode; in_ready depends only on occupancy, clear and reset.
    always_comb begin
        in_ready = arst_n_in && !clear && (count < CW'(DEPTH));
        accept   = in_valid && in_ready;
        pop      = out_valid && out_ready && !clear;
        close    = accept && (in_last || (pk_cnt == 2'd2));
    end

    // Requantize: extend by one bit so rounding cannot wrap, shift, saturate.
    always_comb begin
        ext = {in_data[AW-1], in_data};
`ifdef OUT_PACK_ROUND_EN
        if (shamt != 5'd0) begin
            ext = ext + (XW'(1) << (shamt - 5'd1));
        end
`endif
        shf   = ext >>> shamt;
        qword = shf[IW-1:0];
        qsat  = 1'b0;
        if (shf > SAT_HI) begin
            qword = SAT_HI[IW-1:0];
            qsat  = 1'b1;
        end else if (shf < SAT_LO) begin
            qword = SAT_LO[IW-1:0];
            qsat  = 1'b1;
        end
    end

    // Closing group: buffered lanes plus the incoming word, unused lanes zero.
    always_comb begin
        grp_1 = (pk_cnt == 2'd0) ? qword : pk_1;
        grp_2 = (pk_cnt == 2'd0) ? '0 : ((pk_cnt == 2'd1) ? qword : pk_2);
        grp_3 = (pk_cnt == 2'd2) ? qword : '0;
        grp_n = 2'(pk_cnt + 2'd1);
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_1[i] <= '0;
                mem_2[i] <= '0;
                mem_3[i] <= '0;
                mem_n[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (close) begin
                mem_1[wr_ptr] <= grp_1;
                mem_2[wr_ptr] <= grp_2;
                mem_3[wr_ptr] <= grp_3;
                mem_n[wr_ptr] <= grp_n;
                wr_ptr        <= PW'(wr_ptr + PW'(1));
            end
            if (pop) begin
                rd_ptr <= PW'(rd_ptr + PW'(1));
            end
            case ({close, pop})
                2'b10:   count <= CW'(count + CW'(1));
                2'b01:   count <= CW'(count - CW'(1));
                default: count <= count;
            endcase
        end
    end

    // Packer lanes and sticky saturation flag.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            pk_1   <= '0;
            pk_2   <= '0;
            pk_cnt <= '0;
            sat_q  <= 1'b0;
        end else if (clear) begin
            pk_cnt <= '0;
            sat_q  <= 1'b0;
        end else if (accept) begin
            if (close) begin
                pk_cnt <= '0;
            end else begin
                if (pk_cnt == 2'd0) begin
                    pk_1 <= qword;
                end else begin
                    pk_2 <= qword;
                end
                pk_cnt <= 2'(pk_cnt + 2'd1);
            end
            if (qsat) begin
                sat_q <= 1'b1;
            end
        end
    end

    // Head-entry view; lanes read zero while the FIFO is empty or in reset.
    always_comb begin
        out_valid = (count != '0);
        drive_en  = out_valid;
        sat_seen  = sat_q;
        out_1     = out_valid ? mem_1[rd_ptr] : '0;
        out_2     = out_valid ? mem_2[rd_ptr] : '0;
        out_3     = out_valid ? mem_3[rd_ptr] : '0;
        out_lanes = out_valid ? mem_n[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_out_pack_fifo.sv
// Bench for out_pack_fifo: directed scenarios followed by randomized traffic,
// checked against a queue-based model of groups, packer and saturation flag.
module tb_out_pack_fifo;

    localparam int IW    = 16;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          clear;
    logic [4:0]    shamt;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_1, out_2, out_3;
    logic [1:0]    out_lanes;
    logic          drive_en;
    logic          sat_seen;

    out_pack_fifo #(
        .IO_DATA_WIDTH     (IW),
        .ACCUMULATION_WIDTH(AW),
        .DEPTH             (DEPTH)
    ) dut (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .clear    (clear),
        .shamt    (shamt),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_1    (out_1),
        .out_2    (out_2),
        .out_3    (out_3),
        .out_lanes(out_lanes),
        .drive_en (drive_en),
        .sat_seen (sat_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] l1;
        logic [IW-1:0] l2;
        logic [IW-1:0] l3;
        logic [1:0]    n;
    } grp_t;

    grp_t          mq[$];
    logic [IW-1:0] pk[$];
    bit            msat;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference requantization in plain integer arithmetic.
    function automatic logic [IW-1:0] rq(input logic [AW-1:0] d, input int sh, output bit s);
        longint v;
        longint hi;
        longint lo;
        v  = longint'($signed(d));
        hi = (longint'(1) << (IW - 1)) - 1;
        lo = -(longint'(1) << (IW - 1));
`ifdef OUT_PACK_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        v = v >>> sh;
        s = 1'b0;
        if (v > hi) begin
            v = hi;
            s = 1'b1;
        end else if (v < lo) begin
            v = lo;
            s = 1'b1;
        end
        return IW'(v);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_drive_en"},  64'(drive_en),  64'(0));
        chk({tag, "_out_1"},     64'(out_1),     64'(0));
        chk({tag, "_out_2"},     64'(out_2),     64'(0));
        chk({tag, "_out_3"},     64'(out_3),     64'(0));
        chk({tag, "_out_lanes"}, 64'(out_lanes), 64'(0));
        chk({tag, "_sat_seen"},  64'(sat_seen),  64'(0));
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model past the edge.
    task automatic cyc(input bit v, input logic [AW-1:0] d, input bit last,
                       input bit rdy, input bit clr);
        bit            rdy_exp, acc, pop, s;
        logic [IW-1:0] w;
        grp_t          g;
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = rdy;
        clear     = clr;
        #1;
        rdy_exp = !clr && (mq.size() < DEPTH);
        chk("in_ready",  64'(in_ready),  64'(rdy_exp));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("drive_en",  64'(drive_en),  64'(mq.size() > 0));
        chk("sat_seen",  64'(sat_seen),  64'(msat));
        if (mq.size() > 0) begin
            chk("out_1",     64'(out_1),     64'(mq[0].l1));
            chk("out_2",     64'(out_2),     64'(mq[0].l2));
            chk("out_3",     64'(out_3),     64'(mq[0].l3));
            chk("out_lanes", 64'(out_lanes), 64'(mq[0].n));
        end
        acc = v && rdy_exp;
        pop = rdy && (mq.size() > 0) && !clr;
        @(posedge clk);
        #1;
        if (clr) begin
            mq.delete();
            pk.delete();
            msat = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                w = rq(d, int'(shamt), s);
                if (s) msat = 1'b1;
                pk.push_back(w);
                if (pk.size() == 3 || last) begin
                    g.l1 = pk[0];
                    g.l2 = (pk.size() > 1) ? pk[1] : '0;
                    g.l3 = (pk.size() > 2) ? pk[2] : '0;
                    g.n  = 2'(pk.size());
                    mq.push_back(g);
                    pk.delete();
                end
            end
        end
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, '0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] d;
        arst_n_in = 1'b0;
        clear     = 1'b0;
        shamt     = 5'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        msat      = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        arst_n_in = 1'b1;

        // Three-word group with a saturating third word.
        shamt = 5'd0;
        cyc(1'b1, AW'(5), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(-7), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(40000), 1'b0, 1'b0, 1'b0);
        chk("g3_out_1", 64'(out_1), 64'(16'd5));
        chk("g3_out_2", 64'(out_2), 64'(16'hFFF9));
        chk("g3_out_3", 64'(out_3), 64'(16'd32767));
        chk("g3_lanes", 64'(out_lanes), 64'(3));
        chk("g3_sat",   64'(sat_seen), 64'(1));
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Partial group closed by in_last.
        shamt = 5'd4;
        cyc(1'b1, AW'(32'h100), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(32'h35), 1'b1, 1'b0, 1'b0);
        chk("pg_out_1", 64'(out_1), 64'(16'd16));
        chk("pg_out_3", 64'(out_3), 64'(16'd0));
        chk("pg_lanes", 64'(out_lanes), 64'(2));
        idle(1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Backpressure: 12 words fill all four entries.
        shamt = 5'd0;
        for (int i = 0; i < 12; i++) cyc(1'b1, AW'(i * 3 + 1), 1'b0, 1'b0, 1'b0);
        chk("bp_full", 64'(in_ready), 64'(0));
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Simultaneous push and pop at occupancy 2.
        for (int i = 0; i < 6; i++) cyc(1'b1, AW'(100 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(200), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(201), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(202), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Clear with queued groups, a buffered word, and sat_seen set.
        for (int i = 0; i < 9; i++) cyc(1'b1, AW'(i == 4 ? 90000 : i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(7), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(55), 1'b0, 1'b1, 1'b1);
        chk("clr_valid", 64'(out_valid), 64'(0));
        chk("clr_sat",   64'(sat_seen), 64'(0));
        cyc(1'b1, AW'(11), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(12), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(13), 1'b0, 1'b0, 1'b0);
        chk("clr_fresh_1", 64'(out_1), 64'(16'd11));
        chk("clr_fresh_l", 64'(out_lanes), 64'(3));
        idle(1'b1);

        // Randomized traffic with occasional clears and shift changes.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) begin
                cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
                shamt = 5'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 1) == 1) d = AW'($urandom);
            else d = AW'(int'($urandom_range(0, 4000)) - 2000);
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
        end

        // Async reset in the middle of a burst.
        shamt = 5'd0;
        cyc(1'b1, AW'(70000), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i + 1), 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        arst_n_in = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(posedge clk);
        #1;
        check_reset_outputs("hold");
        arst_n_in = 1'b1;
        mq.delete();
        pk.delete();
        msat = 1'b0;
        idle(1'b0);
        cyc(1'b1, AW'(-3), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, AW'(4), 1'b1, 1'b0, 1'b0);
        chk("rst_after_1", 64'(out_1), 64'(16'hFFFD));
        chk("rst_after_l", 64'(out_lanes), 64'(2));
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
